muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Iterative RV32M multiply/divide engine with its own sequencing FSM, sitting beside the main ALU in the EX stage. It accepts one M-extension operation at a time from EX and runs a 32-step shift-add multiply or restoring divide. While it works it holds the pipeline with `stall`, then presents the result for exactly one cycle. Decode of opcode 0110011 with funct7 = 0000001 into `start` is done upstream; the ALU operation select is not involved.

## Interface
- `XLEN`, 32: operand and result width. Only 32 is supported.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: an M-op is in EX with valid operands. It is held until the op retires.
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1` input XLEN: dividend or multiplicand.
- `rs2` input XLEN: divisor or multiplier.
- `flush` input 1: EX kill from branch/jump redirect.
- `stall` output 1: freezes PC, IF/ID and ID/EX.
- `done` output 1: `result` is valid this cycle; the op retires into EX/MEM.
- `result` output XLEN: final value, held until the next accept.

## Operation
- The FSM has three states: IDLE, CALC and DONE. The reset state is IDLE.
- **IDLE, accept.** A transfer is accepted when `start`=1 and `flush`=0. On accept, the block latches:
  - funct3;
  - the absolute values of the signed operands;
  - the result-sign flags: for MULH/MULHSU, sign(rs1) XOR sign(rs2 if signed); for DIV, the quotient sign; for REM, the remainder sign = sign(rs1);
  - count = 0.
- **Signedness by op.** MULH/DIV/REM treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MULHU/DIVU/REMU and MUL treat both as unsigned. MUL's low 32 bits are sign-agnostic.
- **Special cases.** These go IDLE→DONE directly with the result preloaded:
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF. REM/REMU give rs1.
  - Signed overflow (DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0.
- **All other accepts** go IDLE→CALC.
- **CALC, multiply.** Each cycle adds the multiplicand to the upper half when the product LSB is set, then shifts the 64-bit product/multiplier register right by 1.
- **CALC, divide.** Each cycle shifts {rem, quot} left by 1, subtracts the divisor from rem, and restores rem if the result is negative. The new quotient LSB is the inverse of the borrow.
- **CALC, counter.** The count increments each cycle. When count = 31, the block moves to DONE.
- **DONE.**
  - The final value is registered into `result` on entry, with two's-complement negation applied where the sign flag is set.
  - MUL takes the low word; MULH/MULHSU/MULHU take the high word of the 64-bit product.
  - `done`=1. On the next edge the FSM returns to IDLE unconditionally.
- **Flush.** `flush`=1 in any state forces IDLE on the next edge. `done` must not assert for the killed op, and `result` is left unchanged.
- **Reset.** Synchronous reset in any state forces IDLE, count = 0 and `result` = 0. It has priority over `flush` and `start`.
- **`start` in DONE** is ignored. The retiring op's `start` is still high; a following M-op is first seen in IDLE.

## Timing
- **Reset values:** `stall`=0, `done`=0, `result`=0.
- **Stall:** `stall` = (IDLE & `start` & !`flush`) | CALC. It is combinational from state and inputs, and is 0 in DONE.
- **Normal latency.** Accept edge at cycle 0, CALC on cycles 1–32, DONE at cycle 33 (`done`=1, `stall`=0). That is 33 stall cycles per op.
- **Special-case latency.** Accept at cycle 0, DONE at cycle 1, so 1 stall cycle.
- **Back-to-back ops.** A second M-op enters EX in the cycle after DONE while the FSM is in IDLE, so it is accepted with no bubble beyond its own stall.
- **Output timing.** `done` is high for exactly one cycle per completed op. `result` is registered, not combinational, in DONE.
- **Flush during IDLE with `start`=1.** There is no accept and `stall`=0 that cycle.

## Test plan
- **Reset check.** Assert reset for 2 cycles, then release → IDLE, `stall`=0, `done`=0, `result`=0.
- **MUL and MULH.**
  - MUL rs1=7, rs2=0xFFFFFFFD → `stall` high on cycles 0–32, `done` at cycle 33, `result`=0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- **Signed divide.**
  - DIV rs1=0xFFFFFFF9 (−7), rs2=2 → 0xFFFFFFFD.
  - REM with the same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- **Special cases.**
  - DIV 5/0 → 0xFFFFFFFF with `done` at cycle 1.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at cycle 1.
  - REM with the same operands → 0.
- **Flush mid-operation.** Start DIVU, assert `flush` at cycle 10 → IDLE at cycle 11, no `done`, `result` keeps its prior value. A new MUL 3×4 started at cycle 12 → 12 at cycle 45.
- **Reset and back-to-back.**
  - Reset at cycle 20 of a MUL → IDLE, `result`=0, no `done`.
  - Two consecutive MULs with `start` held through → two `done` pulses 34 cycles apart, each with the correct result.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU, sequenced by an IDLE/CALC/DONE FSM.
// Latency: 33 stall cycles then done on cycle 33 for normal ops; 1 stall cycle, done on cycle 1 for div-by-zero/overflow.
// Backpressure: holds the pipeline via stall while accepting and calculating; flush kills the op, reset wins over all.
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   start, funct3       - M-op present in EX (held until it retires) and its operation select
//   rs1, rs2            - dividend/multiplicand and divisor/multiplier
//   flush               - EX kill; returns to IDLE without done and without touching result
//   stall               - freezes PC, IF/ID, ID/EX (combinational from state and inputs)
//   done, result        - one-cycle retire strobe and registered result (held until the next completion)

module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        op;
    logic              neg;      // result needs two's-complement negation
    logic [XLEN-1:0]   opa;      // multiplicand (mul) or divisor (div), magnitude
    logic [2*XLEN-1:0] acc;      // mul: {product hi, multiplier}; div: {rem, quot}
    logic [CW-1:0]     count;

    // ---------------- accept-side decode ----------------
    logic            s1_signed, s2_signed;
    logic            rs1_neg, rs2_neg;
    logic [XLEN-1:0] abs1, abs2;
    logic            neg_in;
    logic            div0, ovf;
    logic [XLEN-1:0] special_val;

    always_comb begin
        s1_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                    (funct3 == F_DIV)  || (funct3 == F_REM);
        s2_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        rs1_neg   = s1_signed & rs1[XLEN-1];
        rs2_neg   = s2_signed & rs2[XLEN-1];
        abs1      = rs1_neg ? (-rs1) : rs1;
        abs2      = rs2_neg ? (-rs2) : rs2;
        // Remainder takes the dividend's sign; every other signed op takes the XOR.
        // Unsigned operands contribute 0, so MUL/MULHU/DIVU/REMU get neg_in = 0.
        neg_in    = (funct3 == F_REM) ? rs1_neg : (rs1_neg ^ rs2_neg);
        div0      = funct3[2] && (rs2 == '0);
        // Overflow only for the signed div/rem encodings (funct3[0] = 0).
        ovf       = funct3[2] && !funct3[0] && (rs1 == SMIN) && (rs2 == '1);
        // funct3[1] distinguishes REM/REMU from DIV/DIVU.
        if (div0) begin
            special_val = funct3[1] ? rs1 : '1;
        end else begin
            special_val = funct3[1] ? '0 : SMIN;
        end
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     trial;
    logic              borrow;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, acc_nxt;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   div_pick;
    logic [XLEN-1:0]   final_val;

    always_comb begin
        add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opa};
        mul_nxt = acc[0] ? {add_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

        // Trial subtract on the shifted remainder; it is XLEN+1 bits wide, so the
        // top bit of the difference is the borrow.
        trial   = acc[2*XLEN-1:XLEN-1] - {1'b0, opa};
        borrow  = trial[XLEN];
        div_nxt = {(borrow ? acc[2*XLEN-2:XLEN-1] : trial[XLEN-1:0]),
                   acc[XLEN-2:0], ~borrow};

        acc_nxt = op[2] ? div_nxt : mul_nxt;

        // Result as seen after the final step, so DONE can register it on entry.
        prod_fin = neg ? (-acc_nxt) : acc_nxt;
        div_pick = op[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
        if (op[2]) begin
            final_val = neg ? (-div_pick) : div_pick;
        end else if (op == F_MUL) begin
            final_val = prod_fin[XLEN-1:0];
        end else begin
            final_val = prod_fin[2*XLEN-1:XLEN];
        end
    end

    assign stall = ((state == IDLE) && start && !flush) || (state == CALC);

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            result <= '0;
            done   <= 1'b0;
            op     <= '0;
            neg    <= 1'b0;
            opa    <= '0;
            acc    <= '0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op    <= funct3;
                        neg   <= neg_in;
                        count <= '0;
                        if (div0 || ovf) begin
                            result <= special_val;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            opa   <= funct3[2] ? abs2 : abs1;
                            acc   <= {{XLEN{1'b0}}, (funct3[2] ? abs1 : abs2)};
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc   <= acc_nxt;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        result <= final_val;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    // The retiring op's start is still high here; it is deliberately ignored.
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
